// File: rtl/ldst_ctrl_seq.sv
// ldst_ctrl_seq: Moore control sequencer for instruction fetch and the
// load/store class (ld, ldi, st). It drives the datapath strobes step by step
// (T0..T7) and inserts MEM_WAIT extra cycles on every RAM access.
//
// Ports:
//   clk, clr        clock; synchronous active-low reset
//   start           begin fetch and execute of one instruction (sampled in IDLE)
//   ir_opcode       IR[31:27] read back from the datapath after fetch
//   PC_out .. RAM_write_enable   registered datapath strobes
//   opcode          ALU operation select (ADD_OPC in T4, else 0)
//   busy            high in every state except IDLE
//   done            one-cycle completion pulse in DONE
//   illegal         qualifies done when the opcode was unsupported
//
// Configuration macro: LDST_SEQ_CHAIN_EN -- when defined, start=1 in DONE
// issues the next instruction straight into T0 with no IDLE cycle.
module ldst_ctrl_seq #(
  parameter int               OPC_W    = 5,
  parameter int               MEM_WAIT = 1,
  parameter logic [OPC_W-1:0] LD_OPC   = 5'b00000,
  parameter logic [OPC_W-1:0] LDI_OPC  = 5'b00001,
  parameter logic [OPC_W-1:0] ST_OPC   = 5'b00010,
  parameter logic [OPC_W-1:0] ADD_OPC  = 5'b00011
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [OPC_W-1:0] ir_opcode,
  output logic             PC_out,
  output logic             MAR_enable,
  output logic             IncPC,
  output logic             PC_enable,
  output logic             Read,
  output logic             MDR_enable,
  output logic             MDR_out,
  output logic             IR_enable,
  output logic             Gra,
  output logic             Grb,
  output logic             BA_out,
  output logic             Y_enable,
  output logic             C_out,
  output logic             Z_enable,
  output logic             ZLow_out,
  output logic             R_in,
  output logic             RAM_write_enable,
  output logic [OPC_W-1:0] opcode,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, T7, DONE} state_t;
  typedef enum logic [1:0] {CL_LD, CL_LDI, CL_ST, CL_ILL} cls_t;

  localparam logic [3:0] WMAX = 4'(MEM_WAIT);

  state_t     state_r, nstate_s;
  logic [3:0] wcnt_r, nwcnt_s;
  cls_t       cls_r, ncls_s;

  // Next-cycle value of every output; registering these makes the outputs a
  // pure function of the state/wcnt/class registers.
  logic [16:0]      strb_s;
  logic [OPC_W-1:0] opcode_s;
  logic             busy_s, done_s, illegal_s;

  // Map an IR opcode onto the instruction class it selects.
  function automatic cls_t decode_cls(input logic [OPC_W-1:0] op);
    cls_t c;
    if (op == LD_OPC) begin
      c = CL_LD;
    end else if (op == LDI_OPC) begin
      c = CL_LDI;
    end else if (op == ST_OPC) begin
      c = CL_ST;
    end else begin
      c = CL_ILL;
    end
    return c;
  endfunction

  // Next-state, wait-counter and class-latch logic.
  always_comb begin
    nstate_s = state_r;
    ncls_s   = cls_r;
    case (state_r)
      IDLE: if (start) nstate_s = T0; else nstate_s = IDLE;
      T0:   nstate_s = T1;
      T1:   if (wcnt_r == WMAX) nstate_s = T2; else nstate_s = T1;
      T2: begin
        // Class is captured on the edge into T3 so T3's strobes stay Moore.
        nstate_s = T3;
        ncls_s   = decode_cls(ir_opcode);
      end
      T3:   if (cls_r == CL_ILL) nstate_s = DONE; else nstate_s = T4;
      T4:   nstate_s = T5;
      T5:   if (cls_r == CL_LDI) nstate_s = DONE; else nstate_s = T6;
      T6:   if ((cls_r == CL_ST) || (wcnt_r == WMAX)) nstate_s = T7; else nstate_s = T6;
      T7:   if ((cls_r == CL_LD) || (wcnt_r == WMAX)) nstate_s = DONE; else nstate_s = T7;
`ifdef LDST_SEQ_CHAIN_EN
      DONE: if (start) nstate_s = T0; else nstate_s = IDLE;
`else
      DONE: nstate_s = IDLE;
`endif
      default: nstate_s = IDLE;
    endcase
    // wcnt counts cycles spent in the current state; it restarts on any move.
    if ((nstate_s == state_r) && (state_r != IDLE)) begin
      nwcnt_s = wcnt_r + 4'd1;
    end else begin
      nwcnt_s = 4'd0;
    end
  end

  // Strobe decode for the state being entered.
  // strb_s order: PC_out MAR_enable IncPC PC_enable Read MDR_enable MDR_out
  // IR_enable Gra Grb BA_out Y_enable C_out Z_enable ZLow_out R_in RAM_write_enable
  always_comb begin
    strb_s    = 17'd0;
    opcode_s  = {OPC_W{1'b0}};
    busy_s    = (nstate_s != IDLE);
    done_s    = 1'b0;
    illegal_s = 1'b0;
    case (nstate_s)
      T0: strb_s = 17'h1E000;                                 // PC_out MAR IncPC PC_en
      T1: begin
        if (nwcnt_s == WMAX) strb_s = 17'h01800;              // Read MDR_en (last cycle)
        else                 strb_s = 17'h01000;              // Read
      end
      T2: strb_s = 17'h00600;                                 // MDR_out IR_en
      T3: begin
        if (ncls_s == CL_ILL) strb_s = 17'h00000;
        else                  strb_s = 17'h000E0;             // Grb BA_out Y_en
      end
      T4: begin
        strb_s   = 17'h00018;                                 // C_out Z_en
        opcode_s = ADD_OPC;
      end
      T5: begin
        if (ncls_s == CL_LDI) strb_s = 17'h00106;             // ZLow Gra R_in
        else                  strb_s = 17'h08004;             // ZLow MAR
      end
      T6: begin
        if (ncls_s == CL_ST)       strb_s = 17'h00940;        // Gra BA_out MDR_en
        else if (nwcnt_s == WMAX)  strb_s = 17'h01800;        // Read MDR_en
        else                       strb_s = 17'h01000;        // Read
      end
      T7: begin
        if (ncls_s == CL_ST) strb_s = 17'h00401;              // MDR_out RAM_we
        else                 strb_s = 17'h00502;              // MDR_out Gra R_in
      end
      DONE: begin
        done_s    = 1'b1;
        illegal_s = (ncls_s == CL_ILL);
      end
      default: strb_s = 17'd0;
    endcase
  end

  // State, counter, class and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_r <= IDLE;
      wcnt_r  <= 4'd0;
      cls_r   <= CL_LD;
      {PC_out, MAR_enable, IncPC, PC_enable, Read, MDR_enable, MDR_out, IR_enable,
       Gra, Grb, BA_out, Y_enable, C_out, Z_enable, ZLow_out, R_in,
       RAM_write_enable} <= 17'd0;
      opcode  <= {OPC_W{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state_r <= nstate_s;
      wcnt_r  <= nwcnt_s;
      cls_r   <= ncls_s;
      {PC_out, MAR_enable, IncPC, PC_enable, Read, MDR_enable, MDR_out, IR_enable,
       Gra, Grb, BA_out, Y_enable, C_out, Z_enable, ZLow_out, R_in,
       RAM_write_enable} <= strb_s;
      opcode  <= opcode_s;
      busy    <= busy_s;
      done    <= done_s;
      illegal <= illegal_s;
    end
  end

endmodule

// File: doc/ldst_ctrl_seq.md
# ldst_ctrl_seq

Parametrised control sequencer that generates the per-step datapath strobes for instruction fetch and the load/store class (`ld`, `ldi`, `st`). It replaces hand-driven T0–T7 control with a Moore FSM and adds configurable memory wait states. It sits beside `Datapath` and drives its control inputs directly. It reads the IR opcode field back from the datapath after fetch.

## Interface
Parameters:
- `OPC_W`, 5: opcode field width.
- `MEM_WAIT`, 1: extra RAM cycles per access, legal range 0–15.
- `LD_OPC`, 5'b00000: `ld` opcode.
- `LDI_OPC`, 5'b00001: `ldi` opcode.
- `ST_OPC`, 5'b00010: `st` opcode.
- `ADD_OPC`, 5'b00011: ALU add code driven on `opcode` for effective-address computation.

Ports:
- `clk`, in, 1: clock. One clock domain.
- `clr`, in, 1: reset. Synchronous, active-low.
- `start`, in, 1: begin fetch and execute of one instruction.
- `ir_opcode`, in, `OPC_W`: IR[31:27] from the datapath.
- `PC_out`, `MAR_enable`, `IncPC`, `PC_enable`, `Read`, `MDR_enable`, `MDR_out`, `IR_enable`, `Gra`, `Grb`, `BA_out`, `Y_enable`, `C_out`, `Z_enable`, `ZLow_out`, `R_in`, `RAM_write_enable`: out, 1 each. Datapath strobes.
- `opcode`, out, `OPC_W`: ALU operation select.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle completion pulse.
- `illegal`, out, 1: qualifies `done` when the opcode was unsupported.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, T7, DONE. A 4-bit wait counter `wcnt` runs alongside the state register.
- All outputs are decoded from state and `wcnt` only (Moore). Any strobe not listed for a state is 0, and `opcode` is 0.
- IDLE: go to T0 when `start`=1.
- T0: `PC_out`, `MAR_enable`, `IncPC`, `PC_enable`.
- T1: `Read` for 1+`MEM_WAIT` cycles. `MDR_enable` only in the last cycle (`wcnt`==`MEM_WAIT`).
- T2: `MDR_out`, `IR_enable`.
- T3: decode `ir_opcode`.
  - Unsupported opcode: go to DONE with the illegal flag set, asserting no strobes in T3.
  - Otherwise assert `Grb`, `BA_out`, `Y_enable`.
- T4: `C_out`, `Z_enable`, `opcode`=`ADD_OPC`.
- T5:
  - `ldi`: `ZLow_out`, `Gra`, `R_in`, then go to DONE.
  - `ld`/`st`: `ZLow_out`, `MAR_enable`.
- T6:
  - `ld`: `Read` for 1+`MEM_WAIT` cycles, with `MDR_enable` in the last cycle.
  - `st`: `Gra`, `BA_out`, `MDR_enable` for 1 cycle, with `Read`=0.
- T7:
  - `ld`: `MDR_out`, `Gra`, `R_in` for 1 cycle.
  - `st`: `MDR_out`, `RAM_write_enable` for 1+`MEM_WAIT` cycles.
- DONE: `done`=1, and `illegal` reflects the latched flag. Next state is IDLE.
- The decoded opcode class (ld/ldi/st/illegal) is latched at T3 entry. Later changes on `ir_opcode` are ignored.
- `wcnt` clears on every state change and increments while a waited state holds.

## Timing
- Reset: when `clr`=0 at a rising edge, the next state is IDLE, `wcnt`=0 and the flags are cleared. All outputs are 0 after that edge, and `opcode` is 0. This holds in any state, including mid-access.
- `start` is sampled only in IDLE (and in DONE when the configuration macro is defined). `start` is ignored while `busy`.
- Cycles from the `start` edge to the `done` pulse, inclusive of DONE, with W=`MEM_WAIT`:
  - `ldi`: 7+W.
  - `ld`: 9+2W.
  - `st`: 9+2W.
  - illegal: 5+W.
- `Read` and `RAM_write_enable` are never high in the same cycle.
- `MDR_enable` is never high in the same cycle as `MDR_out`.

## Configuration
- `LDST_SEQ_CHAIN_EN` defined: in DONE, if `start`=1 the next state is T0 (back-to-back issue, no IDLE cycle), and `busy` stays high.
- `LDST_SEQ_CHAIN_EN` undefined: DONE always goes to IDLE, so consecutive instructions are separated by at least one IDLE cycle.

## Test plan
- Reset: hold `clr`=0 for 2 cycles with `start`=1, then release → all outputs 0, `busy`=0, and the FSM is in IDLE.
- `ldi`, W=0, `ir_opcode`=00001: pulse `start` → `done` 7 cycles later with `illegal`=0. In T5, `ZLow_out`=`Gra`=`R_in`=1. `RAM_write_enable` is never asserted.
- `ld`, W=2: pulse `start` → `Read` high for 3 cycles in both T1 and T6, with `MDR_enable` only in the third cycle of each; `done` at cycle 13.
- `st`, W=1, `ir_opcode`=00010: `RAM_write_enable` high for exactly 2 cycles in T7 with `MDR_out`=1; `Read`=0 throughout T6–T7; `done` at cycle 11.
- Illegal, `ir_opcode`=11111, W=0: `done`=`illegal`=1 at cycle 5; `Y_enable`, `Z_enable` and `MAR_enable` are never asserted after T0.
- `clr`=0 during the second T6 `Read` cycle of `ld` (W=2) → all outputs 0 on the next edge and no `done` pulse. With `LDST_SEQ_CHAIN_EN` defined, holding `start`=1 gives two `ldi` operations (W=0) with `done` pulses 7 cycles apart.
